// File: rtl/dram_refresh_if.sv
// Refresh request path between the refresh scheduler and dram_controller,
// plus the enable/bus-idle inputs and the CPU-visible status flags.
interface dram_refresh_if;
    logic       en;
    logic       bus_idle;
    logic       refresh_ack;
    logic       refresh_req;
    logic       urgent;
    logic [2:0] pending;
    logic       tick;
    logic       overflow;
    logic       ack_err;

    modport master (
        input  en,
        input  bus_idle,
        input  refresh_ack,
        output refresh_req,
        output urgent,
        output pending,
        output tick,
        output overflow,
        output ack_err
    );

    modport slave (
        output en,
        output bus_idle,
        output refresh_ack,
        input  refresh_req,
        input  urgent,
        input  pending,
        input  tick,
        input  overflow,
        input  ack_err
    );
endinterface

// File: rtl/dram_refresh_scheduler.sv
// Periodic CAS-before-RAS refresh scheduler: owed-refresh backlog,
// REQ/ACK handshake with timeout, idle-window preference and urgency.
module dram_refresh_scheduler #(
    parameter int REFRESH_INTERVAL = 156,
    parameter int MAX_PENDING      = 4,
    parameter int URGENT_LEVEL     = 3,
    parameter int ACK_TIMEOUT      = 32
) (
    input logic            clk_i,
    input logic            rst_i,
    dram_refresh_if.master rif
);
    localparam logic [11:0] RELOAD  = 12'(REFRESH_INTERVAL - 1);
    localparam logic [7:0]  TO_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [2:0]  PMAX    = 3'(MAX_PENDING);
    localparam logic [2:0]  ULVL    = 3'(URGENT_LEVEL);

    typedef enum logic [1:0] {IDLE, REQ, GAP} state_e;

    state_e      state_q;
    logic [11:0] cnt_q;
    logic [7:0]  to_q;
    logic [2:0]  pending_q, pending_d;
    logic        tick_q;
    logic        req_q;
    logic        urgent_q;
    logic        ovf_q;
    logic        err_q;
    logic        dec;
    logic        ovf_hit;

    // The registered tick pulse is the event that adds to the backlog.
    always_comb begin
        dec       = (state_q == REQ) && rif.refresh_ack;
        pending_d = pending_q;
        ovf_hit   = 1'b0;
        if (tick_q && !dec) begin
            if (pending_q == PMAX) ovf_hit = 1'b1;
            else pending_d = pending_q + 3'd1;
        end else if (dec && !tick_q && pending_q != 3'd0) begin
            pending_d = pending_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            cnt_q     <= RELOAD;
            to_q      <= '0;
            pending_q <= '0;
            tick_q    <= 1'b0;
            req_q     <= 1'b0;
            urgent_q  <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            if (rif.en) begin
                if (cnt_q == 12'd0) begin
                    cnt_q  <= RELOAD;
                    tick_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 12'd1;
                end
            end
            pending_q <= pending_d;
            urgent_q  <= (pending_d >= ULVL);
            if (ovf_hit) ovf_q <= 1'b1;

            unique case (state_q)
                IDLE: begin
                    if (pending_q != 3'd0 && (rif.bus_idle || urgent_q)) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        to_q    <= '0;
                    end
                end
                REQ: begin
                    // An ack on the expiry cycle still counts as a success.
                    if (rif.refresh_ack) begin
                        state_q <= GAP;
                        req_q   <= 1'b0;
                    end else if (to_q == TO_LAST) begin
                        state_q <= GAP;
                        req_q   <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        to_q <= to_q + 8'd1;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign rif.refresh_req = req_q;
    assign rif.urgent      = urgent_q;
    assign rif.pending     = pending_q;
    assign rif.tick        = tick_q;
    assign rif.overflow    = ovf_q;
    assign rif.ack_err     = err_q;
endmodule

// File: tb/tb_dram_refresh_scheduler.sv
// Directed bench for dram_refresh_scheduler (interval 8, max 4,
// urgent level 3, ack timeout 4).
module tb_dram_refresh_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    dram_refresh_if rif ();

    dram_refresh_scheduler #(
        .REFRESH_INTERVAL(8),
        .MAX_PENDING(4),
        .URGENT_LEVEL(3),
        .ACK_TIMEOUT(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .rif  (rif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       bi;
        logic       ack;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[17];

    function automatic logic [7:0] e(logic req, logic urg, int p,
                                     logic tk, logic ovf, logic err);
        logic [2:0] p3;
        p3 = 3'(p);
        return {req, urg, p3, tk, ovf, err};
    endfunction

    function automatic logic [7:0] outs();
        return {rif.refresh_req, rif.urgent, rif.pending,
                rif.tick, rif.overflow, rif.ack_err};
    endfunction

    task automatic chk(string nm, logic [7:0] exp);
        logic [7:0] got;
        got = outs();
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s cyc=%0d got req,urg,pend,tick,ovf,err=%b required=%b",
                      nm, cyc, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset(logic en, logic bi);
        rst = 1'b1;
        rif.en = en;
        rif.bus_idle = bi;
        rif.refresh_ack = 1'b0;
        step();
        chk("reset", 8'h00);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        for (int i = 0; i < 17; i++) begin
            tbl[i].en  = 1'b1;
            tbl[i].bi  = 1'b1;
            tbl[i].ack = (i == 12);
            tbl[i].exp = 8'h00;
        end
        tbl[7].exp  = e(0, 0, 0, 1, 0, 0);
        tbl[8].exp  = e(0, 0, 1, 0, 0, 0);
        tbl[9].exp  = e(1, 0, 1, 0, 0, 0);
        tbl[10].exp = e(1, 0, 1, 0, 0, 0);
        tbl[11].exp = e(1, 0, 1, 0, 0, 0);
        tbl[15].exp = e(0, 0, 0, 1, 0, 0);
        tbl[16].exp = e(0, 0, 1, 0, 0, 0);

        // Basic tick / request / ack sequence.
        do_reset(1'b1, 1'b1);
        for (int i = 0; i < 17; i++) begin
            rif.en = tbl[i].en;
            rif.bus_idle = tbl[i].bi;
            rif.refresh_ack = tbl[i].ack;
            step();
            chk($sformatf("basic[%0d]", i), tbl[i].exp);
        end
        rif.refresh_ack = 1'b0;

        // Busy bus: escalation, timeout, saturation, overflow.
        do_reset(1'b1, 1'b0);
        step_to(24); chk("busy_p2", e(0, 0, 2, 1, 0, 0));
        step_to(25); chk("busy_urg", e(0, 1, 3, 0, 0, 0));
        step_to(26); chk("busy_req", e(1, 1, 3, 0, 0, 0));
        step_to(29); chk("to_last_hi", e(1, 1, 3, 0, 0, 0));
        step_to(30); chk("to_drop", e(0, 1, 3, 0, 0, 1));
        step_to(31); chk("to_gap", e(0, 1, 3, 0, 0, 1));
        step_to(32); chk("to_rereq", e(1, 1, 3, 1, 0, 1));
        step_to(33); chk("sat_p4", e(1, 1, 4, 0, 0, 1));
        step_to(40); chk("sat_tick5", e(1, 1, 4, 1, 0, 1));
        step_to(41); chk("ovf_set", e(1, 1, 4, 0, 1, 1));
        step_to(42); chk("ovf_drop", e(0, 1, 4, 0, 1, 1));
        step_to(50); chk("ovf_sticky", e(1, 1, 4, 0, 1, 1));
        do_reset(1'b1, 1'b1);

        // Tick and ack on the same edge with PENDING = 2.
        rif.bus_idle = 1'b0;
        step_to(21); chk("sim2_pre", e(0, 0, 2, 0, 0, 0));
        rif.bus_idle = 1'b1;
        step_to(22); chk("sim2_req", e(1, 0, 2, 0, 0, 0));
        step_to(24); chk("sim2_tick", e(1, 0, 2, 1, 0, 0));
        rif.refresh_ack = 1'b1;
        step_to(25); chk("sim2_hold", e(0, 0, 2, 0, 0, 0));
        rif.refresh_ack = 1'b0;

        // Tick and ack on the same edge with PENDING = MAX.
        do_reset(1'b1, 1'b0);
        step_to(40); chk("simmax_pre", e(1, 1, 4, 1, 0, 1));
        rif.refresh_ack = 1'b1;
        step_to(41); chk("simmax_hold", e(0, 1, 4, 0, 0, 1));
        rif.refresh_ack = 1'b0;

        // Ack on the timeout-expiry cycle, then a stray ack in GAP.
        do_reset(1'b1, 1'b1);
        step_to(13); chk("late_pre", e(1, 0, 1, 0, 0, 0));
        rif.refresh_ack = 1'b1;
        step_to(14); chk("late_ack", 8'h00);
        step_to(15); chk("gap_stray", 8'h00);
        rif.refresh_ack = 1'b0;

        // EN low freezes the interval; stray ack in IDLE; reset mid-request.
        do_reset(1'b0, 1'b1);
        for (int i = 1; i <= 50; i++) begin
            rif.refresh_ack = (i == 20);
            step();
            if (outs() !== 8'h00 || i % 10 == 0) chk($sformatf("en0[%0d]", i), 8'h00);
        end
        rif.refresh_ack = 1'b0;
        rif.en = 1'b1;
        step_to(57); chk("en1_pre", 8'h00);
        step_to(58); chk("en1_tick", e(0, 0, 0, 1, 0, 0));
        step_to(60); chk("en1_req", e(1, 0, 1, 0, 0, 0));
        do_reset(1'b1, 1'b1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dram_refresh_scheduler.md
Name: dram_refresh_scheduler

Overview:
- Generates the periodic CAS-before-RAS refresh requests consumed by dram_controller.
- Keeps a saturating count of refreshes owed and issues them with a REQ/ACK handshake.
- Prefers idle bus windows (AS negated). When the backlog reaches a threshold, it escalates to an urgent request that dram_controller services ahead of CPU cycles.
- Sits directly upstream of dram_controller on the refresh request path; the sticky error flags are visible to the CPU.

Parameters:
- REFRESH_INTERVAL, 156, clocks between refresh ticks (15.6 us at 10 MHz); legal range 2..4095.
- MAX_PENDING, 4, saturation limit of the owed-refresh counter; legal range 1..7.
- URGENT_LEVEL, 3, backlog at which URGENT asserts; must be 1..MAX_PENDING.
- ACK_TIMEOUT, 32, clocks REFRESH_REQ may stay high without an ack before abort; legal range 2..255.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous reset, active-high
- EN  in  1  1 = interval counter runs; 0 = counter holds and ticks are suppressed
- BUS_IDLE  in  1  1 = no CPU cycle in progress (registered AS high)
- REFRESH_ACK  in  1  one-clock pulse from dram_controller when a refresh completes
- REFRESH_REQ  out  1  refresh request to dram_controller, level, held until ack or timeout
- URGENT  out  1  backlog >= URGENT_LEVEL; dram_controller must stall CPU and refresh next
- PENDING  out  3  owed-refresh count
- TICK  out  1  one-clock pulse per elapsed interval
- OVERFLOW  out  1  sticky: a tick arrived while PENDING == MAX_PENDING
- ACK_ERR  out  1  sticky: a request timed out

Behaviour:
- All outputs are registered; there are no combinational paths from inputs to outputs.
- Reset values: interval counter = REFRESH_INTERVAL-1, PENDING=0, state IDLE, REFRESH_REQ=0, URGENT=0, TICK=0, OVERFLOW=0, ACK_ERR=0.
- Reset mid-request drops REFRESH_REQ on the next edge and clears everything, including the sticky flags.
- Interval counter:
  - 12-bit down-counter, decrements each clock while EN=1.
  - On reaching 0 it reloads REFRESH_INTERVAL-1 and TICK pulses on the following cycle.
  - The first TICK after reset is therefore REFRESH_INTERVAL clocks after RST deasserts.
  - EN=0 freezes the count and never produces TICK. Pending refreshes still drain while EN=0.
- PENDING update, per cycle, with tick = TICK-generating event and dec = accepted ack:
  - tick only: +1, saturating at MAX_PENDING.
  - dec only: -1.
  - tick and dec in the same cycle: PENDING is unchanged, even at saturation. No overflow is flagged in this case.
  - tick while PENDING==MAX_PENDING with no dec: PENDING holds and OVERFLOW sets; it clears only on RST.
  - PENDING never underflows.
- URGENT is registered: URGENT = (next PENDING >= URGENT_LEVEL).
- FSM:
  - IDLE: if PENDING != 0 and (BUS_IDLE or URGENT), go to REQ and set REFRESH_REQ=1 on that edge. The timeout counter clears.
  - REQ: REFRESH_REQ stays 1 regardless of BUS_IDLE changes.
    - On REFRESH_ACK: decrement PENDING, drop REFRESH_REQ, go to GAP.
    - Timeout: if the timeout counter reaches ACK_TIMEOUT-1 with no ack, drop REFRESH_REQ, set ACK_ERR, go to GAP. PENDING is not decremented.
  - GAP: exactly one cycle with REFRESH_REQ=0, then IDLE. This guarantees at least 2 low cycles between back-to-back requests.
- REFRESH_ACK received in IDLE or GAP is ignored; PENDING does not change and no flag is set.
- An ack that arrives in the same cycle as the timeout expiry is accepted as an ack; ACK_ERR is not set.

Test Plan:
- Basic tick, with REFRESH_INTERVAL=8, EN=1, BUS_IDLE=1, ack 3 clocks after REQ -> TICK at clock 8 after reset; PENDING 0->1; REQ high 2 clocks after TICK; after ack PENDING=0 and REQ low for >=2 clocks; OVERFLOW=0, ACK_ERR=0.
- Busy bus escalation, with INTERVAL=8, URGENT_LEVEL=3, BUS_IDLE=0 throughout, no ack -> PENDING climbs 1,2,3 at ticks 1..3; REQ stays 0 until URGENT rises with PENDING=3; REQ asserts on the next edge.
- Saturation, with MAX_PENDING=4, EN=1, BUS_IDLE=0, URGENT_LEVEL=4, ACK tied 0, ACK_TIMEOUT large -> PENDING saturates at 4; OVERFLOW sets on the 5th tick and stays set; after RST it reads 0.
- Simultaneous events: arrange an ack on the same clock as a tick with PENDING=2 -> PENDING stays 2. Repeat with PENDING=MAX_PENDING -> PENDING stays MAX_PENDING and OVERFLOW stays 0.
- Timeout, with ACK_TIMEOUT=4 and no ack -> REQ high for exactly 4 clocks, then low; ACK_ERR=1; PENDING unchanged; REQ reasserts after GAP since PENDING>0 and BUS_IDLE=1.
- EN and stray ack: EN=0 for 50 clocks -> no TICK, counter value frozen; a stray REFRESH_ACK in IDLE leaves PENDING=0; RST asserted while REQ is high -> REQ=0 on the next edge and all outputs at their reset values.
